ifu_mc: RTL and testbench

Multi-cycle instruction fetch unit that sits directly upstream of the multi-cycle controller. Holds the PC and the instruction register (IR), computes the next PC from the controller's `npc_sel`, and runs a req/ack handshake to instruction memory. Supplies `op`/`funct` and the other instruction fields to the controller and datapath, and reports `fetch_busy` so the controller can stall in its IF state.

---
 rtl/ifu_mc_pkg.sv | 26 ++
 rtl/ifu_mc_npc_calc.sv | 27 ++
 rtl/ifu_mc.sv | 163 ++++++++++++++++
 tb/tb_ifu_mc.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_mc_pkg.sv
// Shared definitions for the multi-cycle fetch unit and its controller.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package ifu_mc_pkg;

  // Next-PC select encodings, shared with the multi-cycle controller
  localparam logic [2:0] NPC_SEQ = 3'b000;  // pc + 4
  localparam logic [2:0] NPC_J   = 3'b001;  // j / jal target
  localparam logic [2:0] NPC_BR  = 3'b011;  // taken branch target
  localparam logic [2:0] NPC_JR  = 3'b100;  // register target (jr)

  // Default PC after reset
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // Fetch handshake FSM
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } fetch_state_t;

  // Branch displacement: sign-extended word offset converted to a byte offset
  function automatic logic [31:0] br_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_mc_npc_calc.sv
// Next-PC mux for the fetch unit: sequential, jump, branch or register target.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is loaded.
module npc_calc
  import ifu_mc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ir_pc4,
  input  logic [31:0] ir,
  input  logic [31:0] rs_data,
  input  logic [2:0]  npc_sel,
  output logic [31:0] npc
);

  // Select the next PC; reserved select codes fall back to sequential flow
  always_comb begin
    npc = pc + 32'd4;
    case (npc_sel)
      NPC_SEQ: npc = pc + 32'd4;
      NPC_J:   npc = {ir_pc4[31:28], ir[25:0], 2'b00};
      NPC_BR:  npc = ir_pc4 + br_offset(ir[15:0]);
      NPC_JR:  npc = rs_data;
      default: npc = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/ifu_mc.sv
// Multi-cycle instruction fetch unit: PC, IR, next-PC selection and imem req/ack fetch.
// Latency: IR valid the edge after ack (>= 1 cycle after ir_we); abort after TIMEOUT_CYCLES without ack.
// Backpressure: imem_req held until ack or timeout; ir_we ignored while fetch_busy is high.
// Optional feature: define IFU_ALIGN_CHECK_EN to force loaded PCs word-aligned and flag misalign.
module ifu_mc
  import ifu_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_we,
  input  logic        ir_we,
  input  logic [2:0]  npc_sel,
  input  logic [31:0] rs_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] ir_pc4,
  output logic        fetch_busy,
  output logic        fetch_timeout,
  output logic        misalign
);

  // Counter value seen on the last waiting cycle; the next unacked edge aborts
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  fetch_state_t state, state_nxt;
  logic [7:0]   to_cnt;
  logic [31:0]  fetch_addr;
  logic [31:0]  ir;
  logic [31:0]  npc;
  logic [31:0]  pc_load;
  logic         to_last;
  logic         fetch_start;
  logic         fetch_done;
  logic         fetch_abort;

  assign to_last = (to_cnt == TO_LAST);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // FSM next state: start on ir_we, finish on ack or on the timeout edge
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (ir_we) state_nxt = ST_BUSY;
      ST_BUSY: if (imem_ack || to_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; ack wins over a timeout falling on the same edge
  always_comb begin
    imem_req    = 1'b0;
    fetch_busy  = 1'b0;
    fetch_start = 1'b0;
    fetch_done  = 1'b0;
    fetch_abort = 1'b0;
    case (state)
      ST_IDLE: fetch_start = ir_we;
      ST_BUSY: begin
        imem_req    = 1'b1;
        fetch_busy  = 1'b1;
        fetch_done  = imem_ack;
        fetch_abort = !imem_ack && to_last;
      end
      default: ;
    endcase
  end

  // Capture the fetch address from the PC as it was before any same-cycle PC write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             fetch_addr <= 32'd0;
    else if (fetch_start) fetch_addr <= pc;
  end

  assign imem_addr = fetch_addr;

  // Cycles spent waiting for ack in the current fetch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         to_cnt <= 8'd0;
    else if (fetch_start)             to_cnt <= 8'd0;
    else if (fetch_busy && !imem_ack) to_cnt <= to_cnt + 8'd1;
  end

  // IR and link value; an aborted fetch leaves a nop in IR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir     <= 32'd0;
      ir_pc4 <= 32'd0;
    end else if (fetch_done) begin
      ir     <= imem_rdata;
      ir_pc4 <= fetch_addr + 32'd4;
    end else if (fetch_abort) begin
      ir     <= 32'd0;
      ir_pc4 <= fetch_addr + 32'd4;
    end
  end

  // One-cycle abort pulse following the timeout edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fetch_timeout <= 1'b0;
    else      fetch_timeout <= fetch_abort;
  end

  npc_calc u_npc_calc (
    .pc      (pc),
    .ir_pc4  (ir_pc4),
    .ir      (ir),
    .rs_data (rs_data),
    .npc_sel (npc_sel),
    .npc     (npc)
  );

`ifdef IFU_ALIGN_CHECK_EN
  logic misalign_q;

  assign pc_load  = {npc[31:2], 2'b00};
  assign misalign = misalign_q;

  // Sticky flag for any PC load that was not word-aligned
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           misalign_q <= 1'b0;
    else if (pc_we && npc[1:0] != 2'b00) misalign_q <= 1'b1;
  end
`else
  assign pc_load  = npc;
  assign misalign = 1'b0;
`endif

  // PC update, independent of any fetch in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       pc <= RESET_PC;
    else if (pc_we) pc <= pc_load;
  end

  // Instruction field decode
  assign instr = ir;
  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign shamt = ir[10:6];
  assign funct = ir[5:0];
  assign imm16 = ir[15:0];

endmodule

// File: tb/tb_ifu_mc.sv
// Self-checking bench for ifu_mc: cycle model plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_ifu_mc;

  localparam int T = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_we = 1'b0;
  logic        ir_we = 1'b0;
  logic [2:0]  npc_sel = 3'd0;
  logic [31:0] rs_data = 32'd0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [31:0] pc, ir_pc4;
  logic        fetch_busy, fetch_timeout, misalign;

  int n_chk  = 0;
  int n_fail = 0;

  ifu_mc dut (
    .clk           (clk),
    .rst           (rst),
    .pc_we         (pc_we),
    .ir_we         (ir_we),
    .npc_sel       (npc_sel),
    .rs_data       (rs_data),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .op            (op),
    .funct         (funct),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .shamt         (shamt),
    .imm16         (imm16),
    .pc            (pc),
    .ir_pc4        (ir_pc4),
    .fetch_busy    (fetch_busy),
    .fetch_timeout (fetch_timeout),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_ir, m_pc4, m_addr;
  bit          m_busy, m_to, m_mis;
  int          m_wait;

  function automatic logic [31:0] model_npc(input logic [2:0] sel, input logic [31:0] cur_pc,
                                            input logic [31:0] cur_ir, input logic [31:0] cur_pc4,
                                            input logic [31:0] rsd);
    logic signed [31:0] words;
    words = $signed({{16{cur_ir[15]}}, cur_ir[15:0]});
    case (sel)
      3'd1:    return (cur_pc4 & 32'hF000_0000) | ((cur_ir & 32'h03FF_FFFF) * 4);
      3'd3:    return cur_pc4 + 32'(words * 4);
      3'd4:    return rsd;
      default: return cur_pc + 32'd4;
    endcase
  endfunction

  initial forever begin : model
    logic [31:0] nx;
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_pc = 32'h3000; m_ir = 0; m_pc4 = 0; m_addr = 0;
      m_busy = 0; m_to = 0; m_mis = 0; m_wait = 0;
    end else begin
      nx   = model_npc(npc_sel, m_pc, m_ir, m_pc4, rs_data);
      m_to = 0;
      if (m_busy) begin
        if (imem_ack) begin
          m_ir = imem_rdata; m_pc4 = m_addr + 4; m_busy = 0;
        end else begin
          m_wait++;
          if (m_wait >= T) begin
            m_ir = 0; m_pc4 = m_addr + 4; m_busy = 0; m_to = 1;
          end
        end
      end else if (ir_we) begin
        m_busy = 1; m_addr = m_pc; m_wait = 0;
      end
      if (pc_we) begin
`ifdef IFU_ALIGN_CHECK_EN
        if (nx % 4 != 0) begin
          m_mis = 1;
          nx    = nx - (nx % 4);
        end
`endif
        m_pc = nx;
      end
    end
  end

  // Compare every output against the model on each falling edge
  initial forever begin
    @(negedge clk);
    chk("m_req",     imem_req,      32'(m_busy));
    chk("m_busy",    fetch_busy,    32'(m_busy));
    chk("m_addr",    imem_addr,     m_addr);
    chk("m_instr",   instr,         m_ir);
    chk("m_op",      op,            32'(m_ir[31:26]));
    chk("m_rs",      rs,            32'(m_ir[25:21]));
    chk("m_rt",      rt,            32'(m_ir[20:16]));
    chk("m_rd",      rd,            32'(m_ir[15:11]));
    chk("m_shamt",   shamt,         32'(m_ir[10:6]));
    chk("m_funct",   funct,         32'(m_ir[5:0]));
    chk("m_imm16",   imm16,         32'(m_ir[15:0]));
    chk("m_pc",      pc,            m_pc);
    chk("m_ir_pc4",  ir_pc4,        m_pc4);
    chk("m_timeout", fetch_timeout, 32'(m_to));
    chk("m_misalign", misalign,     32'(m_mis));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int busy_cycles;

    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_pc", pc, 32'h3000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ir_pc4", ir_pc4, 32'h0);
    chk("rst_req", imem_req, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_busy", fetch_busy, 32'h0);
    chk("rst_timeout", fetch_timeout, 32'h0);
    chk("rst_misalign", misalign, 32'h0);

    // first fetch, ack on the third edge after ir_we
    ir_we = 1; cyc(); ir_we = 0;
    chk("f1_req", imem_req, 32'h1);
    chk("f1_addr", imem_addr, 32'h3000);
    busy_cycles = 0;
    for (int i = 0; i < 2; i++) begin
      if (fetch_busy) busy_cycles++;
      cyc();
    end
    if (fetch_busy) busy_cycles++;
    imem_ack = 1; imem_rdata = 32'h2108_0001; cyc(); imem_ack = 0;
    chk("f1_busy_cycles", busy_cycles, 32'd3);
    chk("f1_instr", instr, 32'h2108_0001);
    chk("f1_op", op, 32'h08);
    chk("f1_rt", rt, 32'd8);
    chk("f1_imm16", imm16, 32'h1);
    chk("f1_ir_pc4", ir_pc4, 32'h3004);
    chk("f1_req_low", imem_req, 32'h0);

    // advance pc to 0x300C, fetch beq -1 with one-cycle latency, take branch
    pc_we = 1; npc_sel = 3'b000; repeat (3) cyc(); pc_we = 0;
    chk("seq_pc", pc, 32'h300C);
    ir_we = 1; cyc(); ir_we = 0;
    imem_ack = 1; imem_rdata = 32'h1000_FFFF; cyc(); imem_ack = 0;
    chk("beq_instr", instr, 32'h1000_FFFF);
    chk("beq_ir_pc4", ir_pc4, 32'h3010);
    pc_we = 1; npc_sel = 3'b011; cyc(); pc_we = 0;
    chk("br_pc", pc, 32'h300C);

    // jump, jr and reserved select codes
    ir_we = 1; cyc(); ir_we = 0; cyc();
    imem_ack = 1; imem_rdata = 32'h0800_0C10; cyc(); imem_ack = 0;
    pc_we = 1; npc_sel = 3'b001; cyc();
    chk("j_pc", pc, 32'h3040);
    npc_sel = 3'b100; rs_data = 32'h3100; cyc();
    chk("jr_pc", pc, 32'h3100);
    npc_sel = 3'b010; cyc();
    chk("rsv010_pc", pc, 32'h3104);
    npc_sel = 3'b111; cyc();
    chk("rsv111_pc", pc, 32'h3108);
    npc_sel = 3'b100; rs_data = 32'h3000; cyc(); pc_we = 0;
    chk("jr_back_pc", pc, 32'h3000);

    // ir_we with pc_we together; repeated ir_we while busy is ignored
    ir_we = 1; pc_we = 1; npc_sel = 3'b000; cyc(); pc_we = 0;
    chk("same_addr", imem_addr, 32'h3000);
    chk("same_pc", pc, 32'h3004);
    cyc(); cyc(); ir_we = 0;
    imem_ack = 1; imem_rdata = 32'h8C4A_0008; cyc(); imem_ack = 0;
    chk("lw_busy", fetch_busy, 32'h0);
    chk("lw_op", op, 32'h23);
    chk("lw_rs", rs, 32'd2);
    chk("lw_rt", rt, 32'd10);
    cyc();
    chk("one_req", imem_req, 32'h0);
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; cyc(); imem_ack = 0;
    chk("idle_ack_ignored", instr, 32'h8C4A_0008);

    // timeout with no ack
    ir_we = 1; cyc(); ir_we = 0;
    repeat (T - 1) cyc();
    chk("to_still_busy", fetch_busy, 32'h1);
    chk("to_not_yet", fetch_timeout, 32'h0);
    cyc();
    chk("to_pulse", fetch_timeout, 32'h1);
    chk("to_busy_low", fetch_busy, 32'h0);
    chk("to_instr_nop", instr, 32'h0);
    chk("to_ir_pc4", ir_pc4, 32'h3008);
    cyc();
    chk("to_pulse_end", fetch_timeout, 32'h0);

    // ack on the timeout edge wins
    ir_we = 1; cyc(); ir_we = 0;
    repeat (T - 1) cyc();
    imem_ack = 1; imem_rdata = 32'h03E0_0008; cyc(); imem_ack = 0;
    chk("late_instr", instr, 32'h03E0_0008);
    chk("late_funct", funct, 32'h08);
    chk("late_rs", rs, 32'd31);
    chk("late_no_pulse", fetch_timeout, 32'h0);
    chk("late_busy", fetch_busy, 32'h0);
    cyc();
    chk("late_no_pulse2", fetch_timeout, 32'h0);

    // jr to a misaligned target
    pc_we = 1; npc_sel = 3'b100; rs_data = 32'h3102; cyc();
`ifdef IFU_ALIGN_CHECK_EN
    chk("mis_pc", pc, 32'h3100);
    chk("mis_flag", misalign, 32'h1);
`else
    chk("mis_pc", pc, 32'h3102);
    chk("mis_flag", misalign, 32'h0);
`endif
    npc_sel = 3'b000; cyc(); pc_we = 0;
`ifdef IFU_ALIGN_CHECK_EN
    chk("mis_sticky_pc", pc, 32'h3104);
    chk("mis_sticky", misalign, 32'h1);
`else
    chk("mis_sticky_pc", pc, 32'h3106);
    chk("mis_sticky", misalign, 32'h0);
`endif

    // reset mid-fetch drops req immediately; a later ack is ignored
    ir_we = 1; cyc(); ir_we = 0;
    chk("mid_req", imem_req, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("arst_req", imem_req, 32'h0);
    chk("arst_busy", fetch_busy, 32'h0);
    chk("arst_pc", pc, 32'h3000);
    chk("arst_misalign", misalign, 32'h0);
    imem_ack = 1; imem_rdata = 32'hFFFF_FFFF;
    cyc();
    #1 rst = 1'b1;
    cyc(); imem_ack = 0;
    chk("post_rst_instr", instr, 32'h0);
    chk("post_rst_req", imem_req, 32'h0);
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
